// File: rtl/wb4_reg_slice_if.sv
// wb4_reg_slice_if -- Wishbone B4 pipelined bus bundle.
//
// One instance carries one bus segment. The block under it uses the
// "slave" modport on its upstream side and the "master" modport on its
// downstream side.
//
// Signals (master's point of view):
//   cyc, stb, we     : cycle, strobe and write-enable from the master
//   addr, wdata, sel : request address, write data, byte selects
//   stall            : slave cannot take a request this cycle
//   ack              : slave completes one earlier request
//   rdata            : read data, qualified by ack
interface wb4_reg_slice_if #(
  parameter int ARCHBITSZ = 16
);
  logic                   cyc;
  logic                   stb;
  logic                   we;
  logic [ARCHBITSZ-1:0]   addr;
  logic [ARCHBITSZ-1:0]   wdata;
  logic [ARCHBITSZ/8-1:0] sel;
  logic                   stall;
  logic                   ack;
  logic [ARCHBITSZ-1:0]   rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, rdata
  );
endinterface

// File: rtl/wb4_reg_slice.sv
// wb4_reg_slice -- register slice for a Wishbone B4 pipelined bus.
//
// Breaks the combinational paths between an upstream master and a
// downstream slave. Requests pass through a 2-entry in-order FIFO, acks
// and read data come back through one register stage. The number of
// requests issued downstream but not yet acked is capped at MAXPENDING.
//
// Ports:
//   clk_i  : sole clock, rising edge
//   rst_i  : synchronous, active-high reset
//   s_wb4  : upstream bus (this block acts as slave)
//   m_wb4  : downstream bus (this block acts as master)
//
// Handshake: a request transfers on a rising edge where cyc && stb are
// high and stall is low on that segment; every transferred request gets
// exactly one ack, acks come back in request order, and rdata is only
// meaningful in the cycle ack is high. Dropping cyc abandons every request
// not yet acked on that segment.
module wb4_reg_slice #(
  parameter int ARCHBITSZ  = 16,
  parameter int MAXPENDING = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb4_reg_slice_if.slave  s_wb4,
  wb4_reg_slice_if.master m_wb4
);

  localparam int SELW = ARCHBITSZ / 8;
  // Entry layout, MSB first: {we, addr, data, sel}
  localparam int ENTW = 1 + 2 * ARCHBITSZ + SELW;
  localparam logic [3:0] PEND_MAX = 4'(MAXPENDING);

  logic [ENTW-1:0]      ent0_q, ent1_q, ent0_d, ent1_d;
  logic [ENTW-1:0]      push_ent;
  logic [1:0]           occ_q, occ_d;
  logic [3:0]           pend_q, pend_d;
  logic                 cyc_q;
  logic                 stall_q;
  logic                 ack_q;
  logic [ARCHBITSZ-1:0] rdata_q;

  logic push, pop, ack_ok, m_stb;

  assign push_ent = {s_wb4.we, s_wb4.addr, s_wb4.wdata, s_wb4.sel};
  assign push     = s_wb4.cyc && s_wb4.stb && !stall_q;
  assign m_stb    = (occ_q != 2'd0) && cyc_q && (pend_q < PEND_MAX);
  assign pop      = m_stb && !m_wb4.stall;
  // Acks with nothing outstanding are stray and never reach upstream.
  assign ack_ok   = m_wb4.ack && (pend_q != 4'd0);

  // ent0 is always the head. A pop shifts ent1 forward first, then a push
  // lands in the first free slot after that shift, so simultaneous
  // push/pop keeps order without a bubble.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    pend_d = pend_q;

    if (pop) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) ent0_d = push_ent;
      else               ent1_d = push_ent;
      occ_d = occ_d + 2'd1;
    end

    if (pop && !ack_ok)      pend_d = pend_q + 4'd1;
    else if (!pop && ack_ok) pend_d = pend_q - 4'd1;

    // Upstream abort: drop everything buffered and forget outstanding acks.
    if (!s_wb4.cyc) begin
      occ_d  = 2'd0;
      pend_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      occ_q   <= 2'd0;
      pend_q  <= 4'd0;
      cyc_q   <= 1'b0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      cyc_q   <= s_wb4.cyc;
      // Stall is registered, so it must already reflect the occupancy that
      // will exist after this edge.
      stall_q <= (occ_d == 2'd2);
      ack_q   <= ack_ok && s_wb4.cyc;
      rdata_q <= (ack_ok && s_wb4.cyc) ? m_wb4.rdata : '0;
    end
  end

  assign s_wb4.stall = stall_q;
  assign s_wb4.ack   = ack_q;
  assign s_wb4.rdata = rdata_q;

  assign m_wb4.cyc = cyc_q;
  assign m_wb4.stb = m_stb;
  assign {m_wb4.we, m_wb4.addr, m_wb4.wdata, m_wb4.sel} = ent0_q;

endmodule

// File: tb/tb_wb4_reg_slice.sv
// tb_wb4_reg_slice -- self-checking bench for wb4_reg_slice
// (ARCHBITSZ=32, MAXPENDING=2). An upstream driver pushes requests, a
// downstream slave model answers them, and two scoreboard queues hold the
// expected downstream requests and the expected upstream ack data.
module tb_wb4_reg_slice;

  localparam int AW = 32;
  localparam int SW = AW / 8;
  localparam int RW = 1 + 2 * AW + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb4_reg_slice_if #(.ARCHBITSZ(AW)) s_if ();
  wb4_reg_slice_if #(.ARCHBITSZ(AW)) m_if ();

  wb4_reg_slice #(.ARCHBITSZ(AW), .MAXPENDING(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s_wb4 (s_if),
    .m_wb4 (m_if)
  );

  // ---------------- scoreboard state ----------------
  logic [AW-1:0] exp_q[$];
  logic [RW-1:0] dn_exp_q[$];
  logic [AW-1:0] ref_mem[logic [AW-1:0]];
  logic [AW-1:0] slv_mem[logic [AW-1:0]];

  typedef struct {
    int            due;
    logic [AW-1:0] data;
  } rsp_t;
  rsp_t slv_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int up_ack_cnt = 0;
  int dn_acc_cnt = 0;
  int last_ack_cyc = 0;
  int last_acc_cyc = 0;
  int last_up_ack_cyc = 0;
  int acc_cyc_q[$];
  bit mon_en = 1'b0;
  bit stall_seen = 1'b0;
  bit slv_stall = 1'b0;
  int slv_budget = -1;   // -1: ack freely, otherwise acks still allowed

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] dflt_rd(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- downstream slave model ----------------
  rsp_t          slv_r;
  logic [RW-1:0] slv_req;
  logic [AW-1:0] slv_d;

  always @(negedge clk) begin
    m_if.ack   = 1'b0;
    m_if.rdata = '0;
    if (slv_q.size() != 0 && slv_q[0].due <= cyc_cnt && slv_budget != 0) begin
      slv_r      = slv_q.pop_front();
      m_if.ack   = 1'b1;
      m_if.rdata = slv_r.data;
      last_ack_cyc = cyc_cnt;
      if (slv_budget > 0) slv_budget--;
    end
    m_if.stall = slv_stall;
    if (m_if.stb === 1'b1 && !slv_stall) begin
      slv_req = {m_if.we, m_if.addr, m_if.wdata, m_if.sel};
      if (dn_exp_q.size() == 0) check_eq("dn_extra_req", 128'(dn_exp_q.size()), 128'(1));
      else                      check_eq("dn_req", 128'(slv_req), 128'(dn_exp_q.pop_front()));
      if (m_if.we) begin
        slv_mem[m_if.addr] = m_if.wdata;
        slv_d = '0;
      end else begin
        slv_d = slv_mem.exists(m_if.addr) ? slv_mem[m_if.addr] : dflt_rd(m_if.addr);
      end
      slv_q.push_back('{due: cyc_cnt + 1, data: slv_d});
      dn_acc_cnt++;
      last_acc_cyc = cyc_cnt;
      acc_cyc_q.push_back(cyc_cnt);
    end
  end

  // ---------------- upstream monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_if.stall === 1'b1) stall_seen = 1'b1;
      if (s_if.ack === 1'b1) begin
        if (exp_q.size() == 0) check_eq("up_extra_ack", 128'(s_if.ack), 128'(0));
        else                   check_eq("up_ack_data", 128'(s_if.rdata), 128'(exp_q.pop_front()));
        up_ack_cnt++;
        last_up_ack_cyc = cyc_cnt;
      end else begin
        check_eq("up_data_idle", 128'(s_if.rdata), 128'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the push.
  task automatic up_req(input logic we, input logic [AW-1:0] a,
                        input logic [AW-1:0] d, input logic [SW-1:0] sel);
    int n = 0;
    s_if.cyc   = 1'b1;
    s_if.stb   = 1'b1;
    s_if.we    = we;
    s_if.addr  = a;
    s_if.wdata = d;
    s_if.sel   = sel;
    while (s_if.stall === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("push_timeout", 128'(s_if.stall), 128'(0));
    dn_exp_q.push_back({we, a, d, sel});
    if (we) begin
      ref_mem[a] = d;
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : dflt_rd(a));
    end
    @(negedge clk);
    s_if.stb   = 1'b0;
    s_if.we    = 1'b0;
    s_if.addr  = '0;
    s_if.wdata = '0;
    s_if.sel   = '0;
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (dn_acc_cnt < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_eq("acc_wait", 128'(dn_acc_cnt >= target), 128'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || dn_exp_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_left", 128'(exp_q.size() + dn_exp_q.size()), 128'(0));
    @(negedge clk);
    s_if.cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_m_cyc"}, 128'(m_if.cyc), 128'(0));
    check_eq({tag, "_m_stb"}, 128'(m_if.stb), 128'(0));
    check_eq({tag, "_m_head"}, 128'({m_if.we, m_if.addr, m_if.wdata, m_if.sel}), 128'(0));
    check_eq({tag, "_s_stall"}, 128'(s_if.stall), 128'(0));
    check_eq({tag, "_s_ack"}, 128'(s_if.ack), 128'(0));
    check_eq({tag, "_s_data"}, 128'(s_if.rdata), 128'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int base_acc, base_ack;

  initial begin
    s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
    s_if.addr = '0; s_if.wdata = '0; s_if.sel = '0;
    m_if.stall = 1'b0; m_if.ack = 1'b0; m_if.rdata = '0;
    slv_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single read with ack one cycle after the strobe.
    base_ack = up_ack_cnt;
    up_req(1'b0, 32'h100, 32'h0, 4'hF);
    wait_drain();
    check_eq("rd_ack_count", 128'(up_ack_cnt - base_ack), 128'(1));
    check_eq("rd_ack_latency", 128'(last_up_ack_cyc - last_ack_cyc), 128'(1));

    // Back-to-back writes, no downstream stall.
    stall_seen = 1'b0;
    base_ack = up_ack_cnt;
    base_acc = dn_acc_cnt;
    for (int i = 0; i < 4; i++) up_req(1'b1, 32'(i * 4), $urandom(), 4'hF);
    wait_drain();
    check_eq("b2b_ack_count", 128'(up_ack_cnt - base_ack), 128'(4));
    check_eq("b2b_acc_count", 128'(dn_acc_cnt - base_acc), 128'(4));
    check_eq("b2b_consecutive",
             128'(acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-4]), 128'(3));
    check_eq("b2b_no_stall", 128'(stall_seen), 128'(0));

    // Downstream backpressure for 5 cycles during a 3-request burst.
    @(posedge clk);
    stall_seen = 1'b0;
    slv_stall  = 1'b1;
    base_ack = up_ack_cnt;
    base_acc = dn_acc_cnt;
    fork
      begin
        @(negedge clk);
        up_req(1'b0, 32'h0, 32'h0, 4'hF);
        up_req(1'b0, 32'h4, 32'h0, 4'h3);
        up_req(1'b0, 32'h8, 32'h0, 4'hC);
      end
      begin
        repeat (5) @(posedge clk);
        slv_stall = 1'b0;
      end
    join
    wait_drain();
    check_eq("bp_stall_seen", 128'(stall_seen), 128'(1));
    check_eq("bp_ack_count", 128'(up_ack_cnt - base_ack), 128'(3));
    check_eq("bp_acc_count", 128'(dn_acc_cnt - base_acc), 128'(3));

    // Pending limit: acks withheld, only two requests may go out.
    @(posedge clk);
    slv_budget = 0;
    base_ack = up_ack_cnt;
    base_acc = dn_acc_cnt;
    @(negedge clk);
    up_req(1'b0, 32'hC, 32'h0, 4'hF);
    up_req(1'b0, 32'h100, 32'h0, 4'hF);
    up_req(1'b0, 32'($urandom_range(64, 127) * 4), 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    check_eq("pend_acc_limit", 128'(dn_acc_cnt - base_acc), 128'(2));
    check_eq("pend_stb_low", 128'(m_if.stb), 128'(0));
    @(posedge clk);
    slv_budget = 1;
    wait_acc(base_acc + 3);
    check_eq("pend_reissue_lat", 128'(last_acc_cyc - last_ack_cyc), 128'(1));
    @(posedge clk);
    slv_budget = -1;
    wait_drain();
    check_eq("pend_ack_count", 128'(up_ack_cnt - base_ack), 128'(3));

    // Abort with one outstanding and two buffered; the late ack is dropped.
    @(posedge clk);
    slv_budget = 0;
    slv_stall  = 1'b0;
    base_acc = dn_acc_cnt;
    @(negedge clk);
    up_req(1'b0, 32'h40, 32'h0, 4'hF);
    wait_acc(base_acc + 1);
    slv_stall = 1'b1;
    @(negedge clk);
    up_req(1'b0, 32'h44, 32'h0, 4'hF);
    up_req(1'b0, 32'h48, 32'h0, 4'hF);
    check_eq("abort_full_stall", 128'(s_if.stall), 128'(1));
    base_ack = up_ack_cnt;
    s_if.cyc = 1'b0;
    exp_q.delete();
    dn_exp_q.delete();
    @(negedge clk);
    check_eq("abort_m_cyc", 128'(m_if.cyc), 128'(0));
    check_eq("abort_m_stb", 128'(m_if.stb), 128'(0));
    check_eq("abort_s_stall", 128'(s_if.stall), 128'(0));
    @(posedge clk);
    slv_budget = -1;
    slv_stall  = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort_late_ack_sent", 128'(slv_q.size()), 128'(0));
    check_eq("abort_no_up_ack", 128'(up_ack_cnt - base_ack), 128'(0));
    check_eq("abort_no_reissue", 128'(dn_acc_cnt - base_acc), 128'(1));
    check_eq("abort_stb_idle", 128'(m_if.stb), 128'(0));

    // Reset with two buffered requests, then a normal read.
    @(posedge clk);
    slv_stall = 1'b1;
    base_acc = dn_acc_cnt;
    @(negedge clk);
    up_req(1'b0, 32'h80, 32'h0, 4'hF);
    up_req(1'b0, 32'h84, 32'h0, 4'hF);
    rst = 1'b1;
    s_if.cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    dn_exp_q.delete();
    check_idle_outputs("midrst");
    check_eq("midrst_no_issue", 128'(dn_acc_cnt - base_acc), 128'(0));
    @(posedge clk);
    slv_stall = 1'b0;
    base_ack = up_ack_cnt;
    @(negedge clk);
    up_req(1'b0, 32'h8, 32'h0, 4'hF);
    wait_drain();
    check_eq("post_rst_ack_count", 128'(up_ack_cnt - base_ack), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
